// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with run-time baud divider and 3-sample majority vote
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        data_i,
   output logic [7:0]  data_o,
   output logic        done_o,
   output logic        frame_err_o,
   output logic        busy_o,
   input  logic [31:0] baud_div_i
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [2:0]             hist_q;
   logic [31:0]            clk_cnt_q;
   logic [2:0]             bit_idx_q;
   logic [7:0]             shift_q;

   logic        rx_s;
   logic        vote;
   logic [31:0] period_last;
   logic [31:0] start_point;

   assign rx_s = sync_q[SYNC_STAGES-1];

   // The history register holds the three samples taken just before the decision cycle.
   assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

   assign period_last = baud_div_i + 32'd1;
   assign start_point = ((baud_div_i + 32'd2) >> 1) + 32'd1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         sync_q      <= '1;
         hist_q      <= '1;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_o      <= '0;
         done_o      <= 1'b0;
         frame_err_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], data_i};
         hist_q <= {hist_q[1:0], rx_s};
         done_o <= 1'b0;

         case (state_q)
            IDLE: begin
               clk_cnt_q <= '0;
               if (!rx_s) begin
                  state_q <= START;
                  busy_o  <= 1'b1;
               end
            end

            START: begin
               if (clk_cnt_q == start_point) begin
                  clk_cnt_q <= '0;
                  if (!vote) begin
                     state_q   <= DATA;
                     bit_idx_q <= '0;
                  end else begin
                     state_q <= IDLE;
                     busy_o  <= 1'b0;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + 32'd1;
               end
            end

            DATA: begin
               if (clk_cnt_q == period_last) begin
                  clk_cnt_q <= '0;
                  shift_q   <= {vote, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + 32'd1;
               end
            end

            STOP: begin
               if (clk_cnt_q == period_last) begin
                  clk_cnt_q   <= '0;
                  data_o      <= shift_q;
                  done_o      <= 1'b1;
                  frame_err_o <= !vote;
                  if (vote) begin
                     state_q <= IDLE;
                     busy_o  <= 1'b0;
                  end else begin
                     state_q <= BREAK;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + 32'd1;
               end
            end

            // A low stop bit may be a line break; only a return to idle-high re-arms the receiver.
            BREAK: begin
               clk_cnt_q <= '0;
               if (rx_s) begin
                  state_q <= IDLE;
                  busy_o  <= 1'b0;
               end
            end

            default: begin
               state_q   <= IDLE;
               clk_cnt_q <= '0;
               busy_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_i = 1'b1;
   logic [31:0] baud_div = 32'd14;
   logic [7:0]  data_o;
   logic        done;
   logic        ferr;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t_stop = 0;

   logic [7:0] obs_data[$];
   logic       obs_ferr[$];
   int         obs_cyc[$];

   typedef struct {
      int         div;
      logic [7:0] dat;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   uart_rx #(.SYNC_STAGES(SYNC)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .data_i      (data_i),
      .data_o      (data_o),
      .done_o      (done),
      .frame_err_o (ferr),
      .busy_o      (busy),
      .baud_div_i  (baud_div)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && done) begin
         obs_data.push_back(data_o);
         obs_ferr.push_back(ferr);
         obs_cyc.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_obs();
      obs_data.delete();
      obs_ferr.delete();
      obs_cyc.delete();
   endtask

   // Line model: start, 8 data bits LSB first, stop; optional one-cycle inversion at mid-bit of frame position flip_pos.
   task automatic send(input logic [7:0] d, input logic stop, input int p, input int flip_pos, input int extra_low);
      logic [9:0] frame;
      frame = {stop, d, 1'b0};
      for (int pos = 0; pos < 10; pos++) begin
         for (int c = 0; c < p; c++) begin
            if (pos == 9 && c == 0) t_stop = cyc;
            data_i = (pos == flip_pos && c == p / 2) ? ~frame[pos] : frame[pos];
            @(posedge clk);
            #1;
         end
      end
      if (!stop) begin
         data_i = 1'b0;
         idle(extra_low);
      end
      data_i = 1'b1;
   endtask

   task automatic check_one(input string name, input logic [7:0] exp_d, input logic exp_f);
      check({name, "_count"}, obs_data.size(), 1);
      if (obs_data.size() > 0) begin
         check({name, "_data"}, obs_data[0], exp_d);
         check({name, "_ferr"}, obs_ferr[0], exp_f);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL timeout cycles=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] exp_d[$];
      logic       exp_f[$];
      int hi;
      int p;
      int lat;

      vecs[0] = '{14, 8'h55, 1'b1, 8'h55, 1'b0};
      vecs[1] = '{14, 8'h00, 1'b1, 8'h00, 1'b0};
      vecs[2] = '{14, 8'hFF, 1'b1, 8'hFF, 1'b0};
      vecs[3] = '{ 2, 8'h81, 1'b1, 8'h81, 1'b0};
      vecs[4] = '{30, 8'h3C, 1'b1, 8'h3C, 1'b0};
      vecs[5] = '{ 5, 8'hA5, 1'b0, 8'hA5, 1'b1};
      vecs[6] = '{ 7, 8'h6E, 1'b1, 8'h6E, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_data", data_o, 8'h00);
      check("reset_done", done, 1'b0);
      check("reset_ferr", ferr, 1'b0);
      check("reset_busy", busy, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3);

      for (int i = 0; i < 7; i++) begin
         baud_div = vecs[i].div;
         p = vecs[i].div + 2;
         idle(3);
         clear_obs();
         send(vecs[i].dat, vecs[i].stop, p, -1, 0);
         idle(p + 10);
         check_one($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ferr);
         check($sformatf("vec%0d_busy", i), busy, 1'b0);
      end

      // Done latency relative to the stop-bit midpoint on the line.
      baud_div = 14;
      clear_obs();
      send(8'h55, 1'b1, 16, -1, 0);
      idle(30);
      check_one("lat55", 8'h55, 1'b0);
      if (obs_cyc.size() > 0) begin
         lat = obs_cyc[0] - t_stop - 8 - SYNC;
         check("lat55_window", (lat >= 2 && lat <= 4), 1'b1);
      end

      // Short glitch on an idle line: START lasts counter 0..m+1, then false start.
      clear_obs();
      data_i = 1'b0;
      idle(3);
      data_i = 1'b1;
      hi = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) hi++;
      end
      @(posedge clk);
      #1;
      check("glitch_busy_cycles", hi, (16 >> 1) + 2);
      check("glitch_no_strobe", obs_data.size(), 0);

      clear_obs();
      send(8'h00, 1'b1, 16, 3, 0);
      idle(30);
      check_one("pulse_bit2", 8'h00, 1'b0);

      // Break: stop low, then line held low; exactly one strobe, then normal reception.
      clear_obs();
      fork
         send(8'hA5, 1'b0, 16, -1, 40);
         begin
            repeat (180) @(negedge clk);
            check("break_busy", busy, 1'b1);
         end
      join
      idle(60);
      check_one("break_a5", 8'hA5, 1'b1);
      clear_obs();
      send(8'h3C, 1'b1, 16, -1, 0);
      idle(30);
      check_one("after_break_3c", 8'h3C, 1'b0);

      // Reset in the middle of bit 4 of 0xF0.
      clear_obs();
      fork
         send(8'hF0, 1'b1, 16, -1, 0);
         begin
            repeat (5 * 16 + 8) @(posedge clk);
            #1 rst_n = 1'b0;
            @(negedge clk);
            check("midrst_data", data_o, 8'h00);
            check("midrst_done", done, 1'b0);
            check("midrst_ferr", ferr, 1'b0);
            check("midrst_busy", busy, 1'b0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
         end
      join
      idle(20);
      send(8'h12, 1'b1, 16, -1, 0);
      idle(30);
      check_one("after_rst_12", 8'h12, 1'b0);

      // Looped transmitter at P=4; the transmitter spends one clock in idle between frames.
      baud_div = 2;
      idle(5);
      clear_obs();
      for (int v = 0; v < 256; v++) begin
         send(v[7:0], 1'b1, 4, -1, 0);
         idle(1);
      end
      idle(20);
      check("loop_count", obs_data.size(), 256);
      for (int i = 0; i < obs_data.size() && i < 256; i++) begin
         check($sformatf("loop_data%0d", i), obs_data[i], i[7:0]);
         check($sformatf("loop_ferr%0d", i), obs_ferr[i], 1'b0);
      end

      // Random frames against a queue of what the line carried.
      clear_obs();
      for (int n = 0; n < 60; n++) begin
         int div;
         int fp;
         logic [7:0] d;
         logic bad;
         div = $urandom_range(18, 4);
         if (div != baud_div) begin
            idle(baud_div + 8);
            baud_div = div;
         end
         p = div + 2;
         d = 8'($urandom);
         bad = ($urandom_range(5, 0) == 0);
         fp = ($urandom_range(2, 0) == 0) ? $urandom_range(8, 1) : -1;
         send(d, !bad, p, fp, bad ? $urandom_range(20, 0) : 0);
         exp_d.push_back(d);
         exp_f.push_back(bad);
         idle(bad ? p + 4 : $urandom_range(4, 0));
      end
      idle(60);
      check("rand_count", obs_data.size(), exp_d.size());
      for (int i = 0; i < obs_data.size() && i < exp_d.size(); i++) begin
         check($sformatf("rand_data%0d", i), obs_data[i], exp_d[i]);
         check($sformatf("rand_ferr%0d", i), obs_ferr[i], exp_f[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
